pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Program-counter stage of the RISC-V core: a PC register plus an incrementer and a next-PC select.
- Supplies the fetch address (pc_current) and its sequential successor (pc_plus4) to instruction fetch and to the writeback path (link address for JAL/JALR).
- Accepts branch/jump redirects and trap redirects from execute/CSR logic, and a stall from hazard control.

Parameters:
- XLEN, 32, datapath width in bits.
- RESET_VECTOR, 32'h0000_0000, value loaded into the PC on reset.
- PC_INC, 4, sequential increment in bytes.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hold the PC this cycle.
- br_taken  input  1  branch/jump redirect request.
- br_target  input  XLEN  redirect target address.
- trap_valid  input  1  trap/exception redirect request.
- trap_vector  input  XLEN  trap handler address.
- pc_current  output  XLEN  registered current PC (fetch address).
- pc_plus4  output  XLEN  combinational pc_current + PC_INC.
- pc_next_o  output  XLEN  combinational value the PC loads at the next edge.

Behaviour:
- Reset:
  - rst high forces pc_current = RESET_VECTOR immediately, without waiting for a clock edge.
  - During reset, pc_plus4 = RESET_VECTOR + PC_INC.
  - State is held while rst is high. The first update happens on the first rising edge after rst is deasserted.
- pc_plus4 is purely combinational, so it changes in the same cycle as pc_current. Width is XLEN; carry-out is discarded, so 32'hFFFF_FFFC + 4 = 32'h0000_0000 (wrap, no flag).
- Next-PC selection, in strict priority order:
  - 1) trap_valid → trap_vector.
  - 2) stall → pc_current (hold).
  - 3) br_taken → br_target.
  - 4) otherwise → pc_plus4.
- trap_valid overrides stall.
- If stall and br_taken are asserted together, the redirect is NOT latched. Hazard control must hold br_taken until stall drops.
- Latency: pc_current reflects the selected next PC one cycle after the inputs are presented; pc_next_o reflects it in the same cycle.
- Targets are loaded verbatim. Bit 0 is not cleared here; JALR masking is done upstream.
- Reset asserted mid-operation: the PC returns to RESET_VECTOR asynchronously and all pending requests are ignored.
- No X propagation on outputs once reset has been applied.

Optional Feature:
- Macro: PC_MISALIGN_CHECK_EN.
- When defined:
  - Adds output misalign_o (1 bit), driven high combinationally when the selected next PC has bits [1:0] != 2'b00 (taken redirect or trap target).
  - The PC still loads the value as-is; the trap decision belongs to the CSR unit.
  - misalign_o = 0 during reset.
- When undefined: the port is absent and there is no extra logic.

Decomposition:
- Shared package pc_pkg:
  - XLEN_DEFAULT, RESET_VECTOR_DEFAULT, PC_INC_DEFAULT.
  - typedef logic [XLEN-1:0] addr_t.
  - enum pc_sel_e {PC_SEL_TRAP, PC_SEL_HOLD, PC_SEL_BRANCH, PC_SEL_SEQ}, used for the select encoding and by verification coverage.
- One sub-module, pc_adder: combinational operand + PC_INC, parameterised by XLEN.
- The register and next-PC mux stay in pc_unit.

Test Plan:
- Reset then run: rst=1 for one cycle → pc_current=0x0, pc_plus4=0x4. Release rst, then the next edges give pc_current=0x4, 0x8, with pc_plus4=0x8, 0xC.
- Redirect: at pc=0x8 assert br_taken with br_target=0x100 for one cycle → next pc=0x100, pc_plus4=0x104, then 0x104.
- Stall vs trap: at pc=0x10 assert stall for 2 cycles → pc stays 0x10. Assert stall+trap_valid with trap_vector=0x80 → pc=0x80.
- Stall+branch: at pc=0x20, stall=1, br_taken=1, br_target=0x200 → pc stays 0x20. Release stall, keep br_taken → pc=0x200.
- Wrap: from a redirect to 0xFFFF_FFFC → pc_plus4=0x0; the next edge gives pc=0x0.
- Async reset mid-run: at pc=0x40 assert rst between edges → pc_current=RESET_VECTOR before the next edge. With PC_MISALIGN_CHECK_EN defined, br_target=0x102 → misalign_o=1 and pc=0x102.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter stage: default widths, reset vector and the
// next-PC select encoding.
package pc_pkg;

   localparam int unsigned XLEN_DEFAULT         = 32;
   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
   localparam int unsigned PC_INC_DEFAULT       = 4;

   typedef logic [XLEN_DEFAULT-1:0] addr_t;

   typedef enum logic [1:0] {
      PC_SEL_TRAP,
      PC_SEL_HOLD,
      PC_SEL_BRANCH,
      PC_SEL_SEQ
   } pc_sel_e;

endpackage

// File: rtl/pc_unit_if.sv
// Request/response bundle between the PC stage and its neighbours (fetch, execute, hazard).
// PC_MISALIGN_CHECK_EN adds the misalign_o flag.
interface pc_unit_if #(
   parameter int unsigned XLEN = pc_pkg::XLEN_DEFAULT
);
   logic            stall;
   logic            br_taken;
   logic [XLEN-1:0] br_target;
   logic            trap_valid;
   logic [XLEN-1:0] trap_vector;
   logic [XLEN-1:0] pc_current;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] pc_next_o;

`ifdef PC_MISALIGN_CHECK_EN
   logic            misalign_o;

   modport master (
      output stall, br_taken, br_target, trap_valid, trap_vector,
      input  pc_current, pc_plus4, pc_next_o, misalign_o
   );
   modport slave (
      input  stall, br_taken, br_target, trap_valid, trap_vector,
      output pc_current, pc_plus4, pc_next_o, misalign_o
   );
`else
   modport master (
      output stall, br_taken, br_target, trap_valid, trap_vector,
      input  pc_current, pc_plus4, pc_next_o
   );
   modport slave (
      input  stall, br_taken, br_target, trap_valid, trap_vector,
      output pc_current, pc_plus4, pc_next_o
   );
`endif

endinterface

// File: rtl/pc_adder.sv
// Sequential-successor adder: operand + PC_INC, carry-out discarded so the address wraps.
module pc_adder #(
   parameter int unsigned XLEN   = pc_pkg::XLEN_DEFAULT,
   parameter int unsigned PC_INC = pc_pkg::PC_INC_DEFAULT
) (
   input  logic [XLEN-1:0] operand,
   output logic [XLEN-1:0] sum
);

   assign sum = operand + XLEN'(PC_INC);

endmodule

// File: rtl/pc_unit.sv
// PC register with priority next-PC select (trap > stall > branch > sequential).
// PC_MISALIGN_CHECK_EN adds a combinational misaligned-redirect flag.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned    XLEN         = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
   parameter int unsigned    PC_INC       = PC_INC_DEFAULT
) (
   input logic       clk,
   input logic       rst,
   pc_unit_if.slave  bus
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] pc_inc;
   pc_sel_e         sel;

   pc_adder #(
      .XLEN   (XLEN),
      .PC_INC (PC_INC)
   ) u_pc_adder (
      .operand (pc_q),
      .sum     (pc_inc)
   );

   always_comb begin
      sel = PC_SEL_SEQ;
      if (bus.trap_valid) begin
         sel = PC_SEL_TRAP;
      end else if (bus.stall) begin
         // A branch arriving during a stall is dropped; hazard control re-presents it.
         sel = PC_SEL_HOLD;
      end else if (bus.br_taken) begin
         sel = PC_SEL_BRANCH;
      end
   end

   always_comb begin
      pc_d = pc_inc;
      unique case (sel)
         PC_SEL_TRAP:   pc_d = bus.trap_vector;
         PC_SEL_HOLD:   pc_d = pc_q;
         PC_SEL_BRANCH: pc_d = bus.br_target;
         PC_SEL_SEQ:    pc_d = pc_inc;
         default:       pc_d = pc_inc;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q <= RESET_VECTOR;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign bus.pc_current = pc_q;
   assign bus.pc_plus4   = pc_inc;
   assign bus.pc_next_o  = pc_d;

`ifdef PC_MISALIGN_CHECK_EN
   // Only redirect targets can introduce misalignment; the PC still loads them unchanged.
   assign bus.misalign_o = !rst && ((sel == PC_SEL_TRAP) || (sel == PC_SEL_BRANCH)) &&
                           (pc_d[1:0] != 2'b00);
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit: reset, sequential run, redirect priority, wrap, async reset.
// Misalignment vectors run only when PC_MISALIGN_CHECK_EN is defined.
module tb_pc_unit;
   import pc_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   pc_unit_if #(.XLEN(32)) bus ();

   pc_unit #(
      .XLEN         (32),
      .RESET_VECTOR (32'h0000_0000),
      .PC_INC       (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input addr_t obs, input addr_t exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance past one rising edge and settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.stall       = 1'b0;
      bus.br_taken    = 1'b0;
      bus.br_target   = '0;
      bus.trap_valid  = 1'b0;
      bus.trap_vector = '0;
   endtask

   task automatic jump_to(input addr_t target);
      bus.br_taken  = 1'b1;
      bus.br_target = target;
      step();
      bus.br_taken  = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      idle_inputs();
      rst = 1'b1;

      // Reset acts before any clock edge.
      #3;
      check("reset_pc_async", bus.pc_current, 32'h0);
      check("reset_plus4", bus.pc_plus4, 32'h4);
      step();
      check("reset_hold", bus.pc_current, 32'h0);
      rst = 1'b0;

      step();
      check("seq_pc_1", bus.pc_current, 32'h4);
      check("seq_plus4_1", bus.pc_plus4, 32'h8);
      step();
      check("seq_pc_2", bus.pc_current, 32'h8);
      check("seq_plus4_2", bus.pc_plus4, 32'hC);

      // Branch redirect from 0x8.
      bus.br_taken  = 1'b1;
      bus.br_target = 32'h100;
      #1;
      check("br_next_comb", bus.pc_next_o, 32'h100);
      step();
      bus.br_taken = 1'b0;
      check("br_pc", bus.pc_current, 32'h100);
      check("br_plus4", bus.pc_plus4, 32'h104);
      step();
      check("br_seq", bus.pc_current, 32'h104);

      // Stall holds; trap overrides stall.
      jump_to(32'h10);
      bus.stall = 1'b1;
      step();
      check("stall_1", bus.pc_current, 32'h10);
      step();
      check("stall_2", bus.pc_current, 32'h10);
      bus.trap_valid  = 1'b1;
      bus.trap_vector = 32'h80;
      #1;
      check("trap_next_comb", bus.pc_next_o, 32'h80);
      step();
      check("trap_over_stall", bus.pc_current, 32'h80);
      idle_inputs();

      // Trap beats a simultaneous branch.
      bus.trap_valid  = 1'b1;
      bus.trap_vector = 32'h1C0;
      bus.br_taken    = 1'b1;
      bus.br_target   = 32'h2C0;
      step();
      check("trap_over_branch", bus.pc_current, 32'h1C0);
      idle_inputs();

      // Branch during stall is dropped until stall releases.
      jump_to(32'h20);
      bus.stall     = 1'b1;
      bus.br_taken  = 1'b1;
      bus.br_target = 32'h200;
      #1;
      check("stall_br_next", bus.pc_next_o, 32'h20);
      step();
      check("stall_br_hold", bus.pc_current, 32'h20);
      bus.stall = 1'b0;
      step();
      check("br_after_stall", bus.pc_current, 32'h200);
      idle_inputs();

      // Wrap at the top of the address space.
      jump_to(32'hFFFF_FFFC);
      check("wrap_pc", bus.pc_current, 32'hFFFF_FFFC);
      check("wrap_plus4", bus.pc_plus4, 32'h0);
      step();
      check("wrap_next_pc", bus.pc_current, 32'h0);

      // Asynchronous reset mid-run with pending requests.
      jump_to(32'h40);
      check("pre_rst_pc", bus.pc_current, 32'h40);
      #2;
      bus.br_taken    = 1'b1;
      bus.br_target   = 32'h300;
      bus.trap_valid  = 1'b1;
      bus.trap_vector = 32'h380;
      rst = 1'b1;
      #1;
      check("async_rst_pc", bus.pc_current, 32'h0);
      step();
      check("rst_ignores_req", bus.pc_current, 32'h0);
      idle_inputs();
      rst = 1'b0;
      step();
      check("post_rst_seq", bus.pc_current, 32'h4);

`ifdef PC_MISALIGN_CHECK_EN
      check("misalign_seq", addr_t'(bus.misalign_o), 32'h0);
      bus.br_taken  = 1'b1;
      bus.br_target = 32'h102;
      #1;
      check("misalign_br", addr_t'(bus.misalign_o), 32'h1);
      step();
      bus.br_taken = 1'b0;
      check("misalign_pc_loaded", bus.pc_current, 32'h102);
      bus.trap_valid  = 1'b1;
      bus.trap_vector = 32'h81;
      #1;
      check("misalign_trap", addr_t'(bus.misalign_o), 32'h1);
      rst = 1'b1;
      #1;
      check("misalign_in_rst", addr_t'(bus.misalign_o), 32'h0);
      idle_inputs();
      step();
      rst = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
